mem_port_arbiter: RTL and testbench

Arbiter and sequencer sharing one single-port, synchronous-read memory between the pipeline's instruction-fetch port and its data-memory port. Each cycle it grants at most one access and steers the one-cycle-late read data back to the stage that issued it. It also produces the fetch stall that the hazard logic ORs into its PC and IF/ID hold controls. The block sits between the IF/MEM stages and a unified memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Which port owns the read data returning from memory this cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_owner_t;

    // Width of the fetch starvation counter; saturates at its maximum value.
    localparam int STARVE_W = 3;

    // Byte address to word address: drops the two byte-offset bits.
    // Works on a wide container; callers truncate to their word-address width.
    function automatic logic [63:0] word_addr(input logic [63:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;

    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory macro side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, stall_if,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Pipeline stages plus memory macro view
    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, stall_if,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and data access.
// Data has priority; fetch is forced through after STARVE_MAX consecutive data
// grants made while it waited. Read data is steered back one cycle after grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_SAT = {STARVE_W{1'b1}};

    resp_owner_t         resp_q;
    resp_owner_t         resp_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    logic                if_gnt_s;
    logic                d_gnt_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    // Grant decision: data first, fetch when alone or when it has starved long enough.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!rst) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else begin
            case ({bus.if_req, bus.d_req})
                2'b01: d_gnt_s = 1'b1;
                2'b10: if_gnt_s = 1'b1;
                2'b11: begin
                    if (starve_q == STARVE_LIM) begin
                        if_gnt_s = 1'b1;
                    end else begin
                        d_gnt_s = 1'b1;
                    end
                end
                default: begin
                    if_gnt_s = 1'b0;
                    d_gnt_s  = 1'b0;
                end
            endcase
        end
    end

    // Steer address and write data from whichever port holds the grant.
    always_comb begin
        sel_addr_s  = bus.if_addr;
        sel_wdata_s = {DATA_W{1'b0}};
        if (d_gnt_s) begin
            sel_addr_s  = bus.d_addr;
            sel_wdata_s = bus.d_wdata;
        end else begin
            sel_addr_s  = bus.if_addr;
            sel_wdata_s = {DATA_W{1'b0}};
        end
    end

    // Next-state for starvation counter and response owner.
    always_comb begin
        starve_d = starve_q;
        resp_d   = RESP_NONE;

        if (!bus.if_req) begin
            starve_d = {STARVE_W{1'b0}};
        end else if (if_gnt_s) begin
            starve_d = {STARVE_W{1'b0}};
        end else if (d_gnt_s && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + {{(STARVE_W-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end

        // Writes complete on their grant edge and never produce a response.
        if (if_gnt_s) begin
            resp_d = RESP_IF;
        end else if (d_gnt_s && !bus.d_we) begin
            resp_d = RESP_D;
        end else begin
            resp_d = RESP_NONE;
        end
    end

    // State registers; synchronous active-low reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_q   <= RESP_NONE;
            starve_q <= {STARVE_W{1'b0}};
        end else begin
            resp_q   <= resp_d;
            starve_q <= starve_d;
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.stall_if  = bus.if_req & ~if_gnt_s;

    assign bus.mem_en    = if_gnt_s | d_gnt_s;
    assign bus.mem_we    = d_gnt_s & bus.d_we;
    assign bus.mem_addr  = (ADDR_W-2)'(word_addr(64'(sel_addr_s)));
    assign bus.mem_wdata = sel_wdata_s;

    assign bus.if_rvalid = (resp_q == RESP_IF);
    assign bus.d_rvalid  = (resp_q == RESP_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs before sampling, well clear of the edge.
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0;
        bus.d_wdata   = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        idle_inputs();
        bus.mem_rdata = 32'h0;

        // Reset: a request during reset gets no grant and no memory strobe.
        step();
        bus.if_req = 1'b1;
        step();
        settle();
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        chk("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_stall_if",  32'(bus.stall_if),  32'd1);
        step();
        rst = 1'b1;
        idle_inputs();

        // Lone fetch.
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        settle();
        chk("lf_if_gnt",   32'(bus.if_gnt),   32'd1);
        chk("lf_d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("lf_mem_en",   32'(bus.mem_en),   32'd1);
        chk("lf_mem_we",   32'(bus.mem_we),   32'd0);
        chk("lf_mem_addr", 32'(bus.mem_addr), 32'd4);
        chk("lf_stall",    32'(bus.stall_if), 32'd0);
        step();
        bus.if_req    = 1'b0;
        bus.mem_rdata = 32'h2008_0005;
        settle();
        chk("lf_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("lf_if_rdata",  bus.if_rdata,       32'h2008_0005);
        chk("lf_d_rvalid",  32'(bus.d_rvalid),  32'd0);
        chk("lf_mem_en_off", 32'(bus.mem_en),   32'd0);

        // Simultaneous read: data wins, fetch stalls.
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0020;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0040;
        settle();
        chk("sr_d_gnt",    32'(bus.d_gnt),    32'd1);
        chk("sr_if_gnt",   32'(bus.if_gnt),   32'd0);
        chk("sr_stall",    32'(bus.stall_if), 32'd1);
        chk("sr_mem_addr", 32'(bus.mem_addr), 32'h10);
        step();
        bus.d_req     = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        settle();
        chk("sr_d_rvalid",  32'(bus.d_rvalid),  32'd1);
        chk("sr_d_rdata",   bus.d_rdata,        32'h1234_5678);
        chk("sr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("sr_if_gnt2",   32'(bus.if_gnt),    32'd1);
        chk("sr_mem_addr2", 32'(bus.mem_addr),  32'h8);
        step();
        bus.if_req = 1'b0;
        settle();
        chk("sr_if_rvalid2", 32'(bus.if_rvalid), 32'd1);
        chk("sr_d_rvalid2",  32'(bus.d_rvalid),  32'd0);

        // Starvation: six cycles of both requests, fetch forced on cycle 5.
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0200;
        for (int i = 1; i <= 6; i++) begin
            settle();
            chk($sformatf("st_d_gnt_c%0d", i),  32'(bus.d_gnt),  (i == 5) ? 32'd0 : 32'd1);
            chk($sformatf("st_if_gnt_c%0d", i), 32'(bus.if_gnt), (i == 5) ? 32'd1 : 32'd0);
            if (i == 6) begin
                chk("st_if_rvalid_c6", 32'(bus.if_rvalid), 32'd1);
            end else if (i > 1) begin
                chk($sformatf("st_d_rvalid_c%0d", i), 32'(bus.d_rvalid), 32'd1);
            end else begin
                chk("st_d_rvalid_c1", 32'(bus.d_rvalid), 32'd0);
            end
            step();
        end
        idle_inputs();

        // Write: memory write strobe, no response afterwards.
        step();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0008;
        bus.d_wdata = 32'hDEAD_BEEF;
        settle();
        chk("wr_d_gnt",     32'(bus.d_gnt),    32'd1);
        chk("wr_mem_we",    32'(bus.mem_we),   32'd1);
        chk("wr_mem_en",    32'(bus.mem_en),   32'd1);
        chk("wr_mem_wdata", bus.mem_wdata,     32'hDEAD_BEEF);
        chk("wr_mem_addr",  32'(bus.mem_addr), 32'd2);
        step();
        idle_inputs();
        settle();
        chk("wr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("wr_d_rvalid",  32'(bus.d_rvalid),  32'd0);

        // Build starvation count, then reset while a fetch read is in flight.
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0030;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_0050;
        step();
        step();
        bus.d_req = 1'b0;
        settle();
        chk("rm_if_gnt_k", 32'(bus.if_gnt), 32'd1);
        step();
        rst = 1'b0;
        settle();
        chk("rm_if_gnt_rst", 32'(bus.if_gnt), 32'd0);
        chk("rm_mem_en_rst", 32'(bus.mem_en), 32'd0);
        step();
        settle();
        chk("rm_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rm_starve",    32'(dut.starve_q),  32'd0);
        chk("rm_mem_en2",   32'(bus.mem_en),    32'd0);
        step();
        rst = 1'b1;
        idle_inputs();

        // Idle: nothing happens for three cycles.
        for (int i = 1; i <= 3; i++) begin
            step();
            settle();
            chk($sformatf("id_mem_en_c%0d", i),    32'(bus.mem_en),    32'd0);
            chk($sformatf("id_if_gnt_c%0d", i),    32'(bus.if_gnt),    32'd0);
            chk($sformatf("id_d_gnt_c%0d", i),     32'(bus.d_gnt),     32'd0);
            chk($sformatf("id_if_rvalid_c%0d", i), 32'(bus.if_rvalid), 32'd0);
            chk($sformatf("id_d_rvalid_c%0d", i),  32'(bus.d_rvalid),  32'd0);
            chk($sformatf("id_stall_c%0d", i),     32'(bus.stall_if),  32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
